vram_arbiter: RTL and testbench

- Shares one single-port video RAM between two requesters: the VGA scanout fetch port and the CPU load/store port.
- Sits between the display pipeline and the VRAM macro, one level below the top-level.
- Video has priority. A starvation guard guarantees the CPU a slot after a bounded run of video grants.
- All memory-side outputs are registered. The RAM has 1-cycle read latency.

---
 rtl/vram_arbiter.sv | 139 +++++++++++++
 tb/tb_vram_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port VRAM between video scanout (priority) and a CPU port,
// with a starvation guard for the CPU. Define VRAM_ARB_STATS_EN to add stall/starvation counters.
module vram_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  // video fetch port
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_gnt,
  output logic              vid_valid,
  output logic [DATA_W-1:0] vid_data,
  // CPU load/store port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  // RAM macro port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef VRAM_ARB_STATS_EN
  ,
  output logic [15:0]       cpu_stall_cnt,
  output logic [7:0]        starve_hits
`endif
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic       cpu_busy;
  logic [7:0] starve_cnt;

  logic cpu_elig;
  logic starve_hit;
  logic cpu_grant;
  logic vid_grant;

  // Stage-1 tags travel with the access presented on mem_*; stage-2 tags qualify mem_rdata.
  logic s1_vid;
  logic s1_cpu;
  logic s1_cpu_rd;
  logic ack_rd;

  // NOTE: every output of this block is assigned on every path, so no latch can be inferred.
  always_comb begin
    cpu_elig   = cpu_req & ~cpu_busy;
    starve_hit = (starve_cnt == LIMIT);
    cpu_grant  = ~rst & cpu_elig & (~vid_req | starve_hit);
    vid_grant  = ~rst & vid_req & ~cpu_grant;
  end

  assign vid_gnt = vid_grant;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      s1_vid    <= 1'b0;
      s1_cpu    <= 1'b0;
      s1_cpu_rd <= 1'b0;
    end else begin
      mem_en    <= vid_grant | cpu_grant;
      mem_we    <= cpu_grant & cpu_we;
      s1_vid    <= vid_grant;
      s1_cpu    <= cpu_grant;
      s1_cpu_rd <= cpu_grant & ~cpu_we;
      if (cpu_grant) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end else if (vid_grant) begin
        mem_addr  <= vid_addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vid_valid <= 1'b0;
      cpu_ack   <= 1'b0;
      ack_rd    <= 1'b0;
    end else begin
      vid_valid <= s1_vid;
      cpu_ack   <= s1_cpu;
      ack_rd    <= s1_cpu_rd;
    end
  end

  // Read data is only driven while qualified, so the data buses idle at zero.
  assign vid_data  = vid_valid ? mem_rdata : '0;
  assign cpu_rdata = (cpu_ack & ack_rd) ? mem_rdata : '0;

  // cpu_busy masks the held request from grant until its ack retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_busy   <= 1'b0;
      starve_cnt <= '0;
    end else begin
      if (cpu_grant) begin
        cpu_busy <= 1'b1;
      end else if (cpu_ack) begin
        cpu_busy <= 1'b0;
      end

      if (cpu_grant || !cpu_elig) begin
        starve_cnt <= '0;
      end else if (vid_grant && !starve_hit) begin
        starve_cnt <= 8'(starve_cnt + 8'd1);
      end
    end
  end

`ifdef VRAM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_stall_cnt <= '0;
      starve_hits   <= '0;
    end else begin
      if (cpu_elig && !cpu_grant && cpu_stall_cnt != 16'hFFFF) begin
        cpu_stall_cnt <= 16'(cpu_stall_cnt + 16'd1);
      end
      if (cpu_grant && vid_req && starve_hit) begin
        starve_hits <= 8'(starve_hits + 8'd1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: RAM model, video scoreboard, CPU vector table
// and directed sequences for starvation, back-to-back CPU requests and mid-operation reset.
module tb_vram_arbiter;

  localparam int ADDR_W       = 13;
  localparam int DATA_W       = 16;
  localparam int STARVE_LIMIT = 8;

  logic              clk;
  logic              rst;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_gnt;
  logic              vid_valid;
  logic [DATA_W-1:0] vid_data;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
`ifdef VRAM_ARB_STATS_EN
  logic [15:0]       cpu_stall_cnt;
  logic [7:0]        starve_hits;
`endif

  vram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
    .vid_valid(vid_valid), .vid_data(vid_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef VRAM_ARB_STATS_EN
    , .cpu_stall_cnt(cpu_stall_cnt), .starve_hits(starve_hits)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Background contents of RAM words the CPU has not written.
  function automatic logic [15:0] pat(input logic [12:0] a);
    return {3'b101, a} ^ 16'h0F0F;
  endfunction

  // RAM model with one-cycle read latency.
  logic [DATA_W-1:0] ram     [0:(1<<ADDR_W)-1];
  bit                written [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]     <= mem_wdata;
        written[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= written[mem_addr] ? ram[mem_addr] : pat(mem_addr);
      end
    end
  end

  // Scoreboard: video grants push expected data; vid_valid pops and compares.
  typedef struct {
    logic [15:0] data;
    int          due;
  } vexp_t;

  typedef struct {
    int          at;
    logic        we;
    logic [12:0] addr;
    logic [15:0] wdata;
  } acc_t;

  vexp_t       vq[$];
  acc_t        acc_q[$];
  vexp_t       ve;
  logic        prev_vid_gnt  = 1'b0;
  logic [12:0] prev_vid_addr = '0;
  int          vid_valid_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_vid_gnt <= 1'b0;
      vq.delete();
    end else begin
      if (prev_vid_gnt) begin
        check("vid_mem_en",   32'(mem_en),   32'd1);
        check("vid_mem_we",   32'(mem_we),   32'd0);
        check("vid_mem_addr", 32'(mem_addr), 32'(prev_vid_addr));
      end else if (mem_en) begin
        acc_q.push_back('{at: cyc, we: mem_we, addr: mem_addr, wdata: mem_wdata});
      end
      if (vid_valid) begin
        if (vq.size() == 0) begin
          check("vid_valid_unexpected", 32'd1, 32'd0);
        end else begin
          ve = vq.pop_front();
          check("vid_data",      32'(vid_data), 32'(ve.data));
          check("vid_valid_lat", 32'(cyc),      32'(ve.due));
        end
        vid_valid_cnt <= vid_valid_cnt + 1;
      end
      if (vid_gnt) vq.push_back('{data: pat(vid_addr), due: cyc + 2});
      prev_vid_gnt  <= vid_gnt;
      prev_vid_addr <= vid_addr;
    end
  end

  typedef struct {
    logic        we;
    logic [12:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
  } cpu_vec_t;

  cpu_vec_t vecs[9];

  // One isolated CPU access on an otherwise idle RAM: grant at N, RAM access at N+1, ack at N+2.
  task automatic run_cpu(input cpu_vec_t v);
    int          start;
    int          ack_at;
    bit          got;
    logic [15:0] rd;
    acc_t        a;
    @(posedge clk); #1;
    acc_q.delete();
    cpu_req   = 1'b1;
    cpu_we    = v.we;
    cpu_addr  = v.addr;
    cpu_wdata = v.wdata;
    start     = cyc;
    got       = 1'b0;
    ack_at    = 0;
    rd        = '0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (cpu_ack) begin
        got    = 1'b1;
        ack_at = cyc;
        rd     = cpu_rdata;
      end
    end
    check("cpu_ack_seen", 32'(got), 32'd1);
    if (got) begin
      check("cpu_ack_lat", 32'(ack_at - start), 32'd2);
      if (!v.we) check("cpu_rdata", 32'(rd), 32'(v.exp_rdata));
      check("cpu_mem_count", 32'(acc_q.size()), 32'd1);
      if (acc_q.size() > 0) begin
        a = acc_q.pop_front();
        check("cpu_mem_at",   32'(a.at - start), 32'd1);
        check("cpu_mem_we",   32'(a.we),         32'(v.we));
        check("cpu_mem_addr", 32'(a.addr),       32'(v.addr));
        if (v.we) check("cpu_mem_wdata", 32'(a.wdata), 32'(v.wdata));
      end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
    acc_q.delete();
  endtask

  // Continuous video with a CPU read raised at t=10: LIMIT more video grants, one CPU slot.
  task automatic run_starve();
    int   vidx  = 0;
    int   base  = 0;
    bit   acked = 1'b0;
    logic exp_gnt;
    acc_t a;
    acc_q.delete();
    for (int t = 0; t < 30; t++) begin
      @(posedge clk); #1;
      if (t == 0) base = cyc;
      vid_req  = (t < 28);
      vid_addr = 13'(13'h200 + vidx);
      if (t == 10) begin
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 13'h0123;
      end
      if (acked) cpu_req = 1'b0;
      @(negedge clk);
      exp_gnt = (t == 10 + STARVE_LIMIT) ? 1'b0 : (t < 28);
      check("starve_vid_gnt", 32'(vid_gnt), 32'(exp_gnt));
      if (vid_gnt) vidx++;
      if (cpu_ack) begin
        check("starve_ack_at", 32'(t),         32'(10 + STARVE_LIMIT + 2));
        check("starve_rdata",  32'(cpu_rdata), 32'h1234);
        acked = 1'b1;
      end
    end
    check("starve_acked",     32'(acked),        32'd1);
    check("starve_mem_count", 32'(acc_q.size()), 32'd1);
    if (acc_q.size() > 0) begin
      a = acc_q.pop_front();
      check("starve_mem_at",   32'(a.at - base), 32'(10 + STARVE_LIMIT + 1));
      check("starve_mem_addr", 32'(a.addr),      32'h0123);
    end
    acc_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1);
  end

  initial begin
    int   vbase;
    int   start;
    int   n_ack;
    int   acks[$];
    rst       = 1'b1;
    vid_req   = 1'b1;
    vid_addr  = '0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;

    vecs[0] = '{1'b1, 13'h0123, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b0, 13'h0123, 16'h0000, 16'hBEEF};
    vecs[2] = '{1'b1, 13'h0040, 16'h0001, 16'h0000};
    vecs[3] = '{1'b1, 13'h1FFF, 16'hFFFF, 16'h0000};
    vecs[4] = '{1'b0, 13'h1FFF, 16'h0000, 16'hFFFF};
    vecs[5] = '{1'b0, 13'h0040, 16'h0000, 16'h0001};
    vecs[6] = '{1'b0, 13'h0050, 16'h0000, pat(13'h0050)};
    vecs[7] = '{1'b1, 13'h0123, 16'h1234, 16'h0000};
    vecs[8] = '{1'b0, 13'h0123, 16'h0000, 16'h1234};

    // Reset state, with vid_req held high to show grants are suppressed.
    repeat (3) @(negedge clk);
    check("rst_vid_gnt",   32'(vid_gnt),   32'd0);
    check("rst_mem_en",    32'(mem_en),    32'd0);
    check("rst_mem_we",    32'(mem_we),    32'd0);
    check("rst_mem_addr",  32'(mem_addr),  32'd0);
    check("rst_vid_valid", 32'(vid_valid), 32'd0);
    check("rst_cpu_ack",   32'(cpu_ack),   32'd0);
    @(posedge clk); #1;
    rst     = 1'b0;
    vid_req = 1'b0;

    foreach (vecs[i]) run_cpu(vecs[i]);

    // Streaming video over addresses 0..15: a grant every cycle, valid two cycles later.
    vbase = vid_valid_cnt;
    for (int t = 0; t < 16; t++) begin
      @(posedge clk); #1;
      vid_req  = 1'b1;
      vid_addr = 13'(t);
      @(negedge clk);
      check("stream_vid_gnt", 32'(vid_gnt), 32'd1);
    end
    @(posedge clk); #1;
    vid_req = 1'b0;
    repeat (3) @(negedge clk);
    check("stream_valid_count", 32'(vid_valid_cnt - vbase), 32'd16);

    run_starve();
    run_starve();
`ifdef VRAM_ARB_STATS_EN
    check("stats_stall_cnt", 32'(cpu_stall_cnt), 32'd16);
    check("stats_starve_hits", 32'(starve_hits), 32'd2);
`endif

    // CPU request held across its ack with new fields: second grant the cycle after the ack.
    acc_q.delete();
    acks.delete();
    start = 0;
    for (int t = 0; t < 9; t++) begin
      @(posedge clk); #1;
      if (t == 0) begin
        start     = cyc;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 13'h0300;
        cpu_wdata = 16'h1111;
      end
      if (t == 3) begin
        cpu_addr  = 13'h0301;
        cpu_wdata = 16'h2222;
      end
      if (t == 6) cpu_req = 1'b0;
      @(negedge clk);
      if (cpu_ack) acks.push_back(t);
    end
    check("b2b_ack_count", 32'(acks.size()), 32'd2);
    if (acks.size() == 2) begin
      check("b2b_ack0_at", 32'(acks[0]), 32'd2);
      check("b2b_ack1_at", 32'(acks[1]), 32'd5);
    end
    check("b2b_mem_count", 32'(acc_q.size()), 32'd2);
    if (acc_q.size() == 2) begin
      check("b2b_mem0_at",    32'(acc_q[0].at - start), 32'd1);
      check("b2b_mem0_addr",  32'(acc_q[0].addr),       32'h0300);
      check("b2b_mem0_wdata", 32'(acc_q[0].wdata),      32'h1111);
      check("b2b_mem1_at",    32'(acc_q[1].at - start), 32'd4);
      check("b2b_mem1_addr",  32'(acc_q[1].addr),       32'h0301);
      check("b2b_mem1_wdata", 32'(acc_q[1].wdata),      32'h2222);
    end
    acc_q.delete();

    // Reset the cycle after a CPU read grant: the access is dropped and never acked.
    @(posedge clk); #1;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 13'h0123;
    @(negedge clk);
    @(posedge clk); #1;
    rst     = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    check("midrst_mem_en_inflight", 32'(mem_en), 32'd1);
    @(posedge clk); #1;
    vid_req = 1'b1;
    @(negedge clk);
    check("midrst_vid_gnt",   32'(vid_gnt),   32'd0);
    check("midrst_mem_en",    32'(mem_en),    32'd0);
    check("midrst_mem_we",    32'(mem_we),    32'd0);
    check("midrst_mem_addr",  32'(mem_addr),  32'd0);
    check("midrst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("midrst_vid_valid", 32'(vid_valid), 32'd0);
    check("midrst_vid_data",  32'(vid_data),  32'd0);
    check("midrst_cpu_ack",   32'(cpu_ack),   32'd0);
    check("midrst_cpu_rdata", 32'(cpu_rdata), 32'd0);
`ifdef VRAM_ARB_STATS_EN
    check("midrst_stall_cnt",   32'(cpu_stall_cnt), 32'd0);
    check("midrst_starve_hits", 32'(starve_hits),   32'd0);
`endif
    @(posedge clk); #1;
    rst     = 1'b0;
    vid_req = 1'b0;
    n_ack   = 0;
    repeat (6) begin
      @(negedge clk);
      if (cpu_ack) n_ack++;
    end
    check("midrst_no_ack", 32'(n_ack), 32'd0);
    run_cpu(vecs[8]);

    check("vid_queue_empty", 32'(vq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
